// File: rtl/armleocpu_muldiv_if.sv
// armleocpu_muldiv_if: request/response handshake bundle for the mul/div unit
interface armleocpu_muldiv_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;
  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, kill, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );
  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, kill, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/armleocpu_muldiv.sv
// armleocpu_muldiv: iterative RV M-extension unit, shift-add multiply and restoring divide
module armleocpu_muldiv #(
  parameter int XLEN          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input logic              clk,
  input logic              rst,
  armleocpu_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        f_q, f_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] mc_q, mc_d, acc_q, acc_d;
  logic              negq_q, negq_d, negr_q, negr_d;
  logic              s1, s2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2, spec_res, q, r, mul_res, div_res;
  logic [2*XLEN-1:0] mul_acc, prod, div_acc;
  logic [XLEN:0]     t, diff;
  always_comb begin
    s1       = bus.req_funct3[2] ? ~bus.req_funct3[0] : ^bus.req_funct3[1:0];
    s2       = bus.req_funct3[2] ? ~bus.req_funct3[0] : (bus.req_funct3[1:0] == 2'b01);
    neg1     = s1 & bus.req_rs1[XLEN-1];
    neg2     = s2 & bus.req_rs2[XLEN-1];
    mag1     = neg1 ? -bus.req_rs1 : bus.req_rs1;
    mag2     = neg2 ? -bus.req_rs2 : bus.req_rs2;
    div0     = bus.req_rs2 == '0;
    ovf      = ~bus.req_funct3[0] && bus.req_rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.req_rs2 == '1;
    spec_res = bus.req_funct3[1] ? (div0 ? bus.req_rs1 : '0) : (div0 ? '1 : bus.req_rs1);
  end
  // one multiply step: add the shifted multiplicand for each consumed multiplier bit
  always_comb begin
    mul_acc = acc_q;
    for (int k = 0; k < MUL_STEP_BITS; k++)
      if (b_q[k]) mul_acc = mul_acc + (mc_q << k);
    prod    = negq_q ? -mul_acc : mul_acc;
    mul_res = f_q == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end
  // acc holds {partial remainder, dividend bits shifting into quotient bits}
  always_comb begin
    t       = acc_q[2*XLEN-1:XLEN-1];
    diff    = t - {1'b0, b_q};
    div_acc = {diff[XLEN] ? t[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], ~diff[XLEN]};
    q       = div_acc[XLEN-1:0];
    r       = div_acc[2*XLEN-1:XLEN];
    div_res = f_q[1] ? (negr_q ? -r : r) : (negq_q ? -q : q);
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f_d      = f_q;
    b_d      = b_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        f_d    = bus.req_funct3[1:0];
        b_d    = mag2;
        negq_d = neg1 ^ neg2;
        negr_d = neg1;
        if (!bus.req_funct3[2]) begin
          state_d = MUL;
          cnt_d   = CW'(XLEN / MUL_STEP_BITS);
          mc_d    = {{XLEN{1'b0}}, mag1};
          acc_d   = '0;
        end else if (div0 || ovf) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = spec_res;
        end else begin
          state_d = DIV;
          cnt_d   = CW'(XLEN);
          acc_d   = {{XLEN{1'b0}}, mag1};
        end
      end
      MUL: begin
        acc_d = mul_acc;
        mc_d  = mc_q << MUL_STEP_BITS;
        b_d   = b_q >> MUL_STEP_BITS;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = mul_res;
        end
      end
      DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = div_res;
        end
      end
      DONE: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.kill) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f_q      <= '0;
      b_q      <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f_q      <= f_d;
      b_q      <= b_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end
  assign bus.req_ready   = state_q == IDLE;
  assign bus.resp_valid  = state_q == DONE;
  assign bus.busy        = state_q != IDLE;
  assign bus.resp_result = result_q;
endmodule

// File: tb/tb_armleocpu_muldiv.sv
// tb_armleocpu_muldiv: random and directed checks of two unit configurations against an arithmetic model
module tb_armleocpu_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  armleocpu_muldiv_if #(.XLEN(32)) b1 ();
  armleocpu_muldiv_if #(.XLEN(32)) b4 ();
  armleocpu_muldiv #(.XLEN(32), .MUL_STEP_BITS(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  armleocpu_muldiv #(.XLEN(32), .MUL_STEP_BITS(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  int npass = 0;
  int nchk  = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic drv(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    b1.req_valid = v; b1.req_funct3 = f; b1.req_rs1 = a; b1.req_rs2 = b;
    b4.req_valid = v; b4.req_funct3 = f; b4.req_rs1 = a; b4.req_rs2 = b;
  endtask
  task automatic ctl(input logic k, input logic rr);
    b1.kill = k; b1.resp_ready = rr;
    b4.kill = k; b4.resp_ready = rr;
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint unsigned pu;
    int sa, sb;
    logic ov;
    sa = a; sb = b;
    ov = a == 32'h80000000 && b == 32'hffffffff;
    case (f)
      3'd0: begin pu = {32'h0, a} * {32'h0, b}; return pu[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'd4: return b == 0 ? 32'hffffffff : ov ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hffffffff : a / b;
      3'd6: return b == 0 ? a : ov ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int s);
    if (!f[2]) return 32 / s + 1;
    if (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hffffffff)) return 1;
    return 33;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction
  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int l1 = 0, l4 = 0;
    logic [31:0] r1 = 0, r4 = 0, exp;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 100 && !(b1.req_ready && b4.req_ready); i++) @(negedge clk);
    chk("ready", {b1.req_ready, b4.req_ready}, 2'b11);
    drv(1'b1, f, a, b);
    @(posedge clk);
    #1 drv($urandom, 3'($urandom), $urandom, $urandom);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (l1 == 0 && b1.resp_valid) begin l1 = c; r1 = b1.resp_result; end
      if (l4 == 0 && b4.resp_valid) begin l4 = c; r4 = b4.resp_result; end
      if (l1 != 0 && l4 != 0) break;
      @(posedge clk);
      #1 drv($urandom, 3'($urandom), $urandom, $urandom);
    end
    drv(1'b0, 3'd0, 32'h0, 32'h0);
    exp = model(f, a, b);
    chk($sformatf("f%0d %h %h lat1", f, a, b), l1, lat_model(f, a, b, 1));
    chk($sformatf("f%0d %h %h lat4", f, a, b), l4, lat_model(f, a, b, 4));
    chk($sformatf("f%0d %h %h res1", f, a, b), r1, exp);
    chk($sformatf("f%0d %h %h res4", f, a, b), r4, exp);
    if (hold) begin
      ok = 1'b1;
      repeat (10) begin
        @(negedge clk);
        ok &= b1.resp_valid && !b1.req_ready && b1.resp_result == r1;
        ok &= b4.resp_valid && !b4.req_ready && b4.resp_result == r4;
      end
      chk("hold", ok, 1'b1);
    end
    ctl(1'b0, 1'b1);
    @(posedge clk);
    #1 ctl(1'b0, 1'b0);
    @(negedge clk);
    chk("idle", {b1.req_ready, b1.resp_valid, b1.busy, b4.req_ready, b4.resp_valid, b4.busy}, 6'b100100);
  endtask
  task automatic quiet(input string tag);
    bit ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      ok &= !b1.resp_valid && !b4.resp_valid;
    end
    chk(tag, ok, 1'b1);
  endtask
  initial begin
    drv(1'b0, 3'd0, 32'h0, 32'h0);
    ctl(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst flags", {b1.req_ready, b1.resp_valid, b1.busy, b4.req_ready, b4.resp_valid, b4.busy}, 6'b100100);
    chk("rst result", {b1.resp_result, b4.resp_result}, 64'h0);
    rst = 1'b0;
    op(3'd1, 32'h80000000, 32'h80000000, 1'b1);
    op(3'd0, 32'h80000000, 32'h80000000, 1'b0);
    op(3'd2, 32'hffffffff, 32'hffffffff, 1'b0);
    op(3'd3, 32'hffffffff, 32'hffffffff, 1'b0);
    op(3'd4, 32'hfffffff9, 32'd2, 1'b1);
    op(3'd6, 32'hfffffff9, 32'd2, 1'b0);
    op(3'd5, 32'd100, 32'd7, 1'b0);
    op(3'd7, 32'd100, 32'd7, 1'b0);
    op(3'd5, 32'd7, 32'd0, 1'b1);
    op(3'd7, 32'd7, 32'd0, 1'b0);
    op(3'd4, 32'h80000000, 32'hffffffff, 1'b0);
    op(3'd6, 32'h80000000, 32'hffffffff, 1'b0);
    op(3'd4, 32'hfffffff0, 32'd0, 1'b0);
    op(3'd6, 32'hfffffff0, 32'd0, 1'b0);
    repeat (60) op(3'($urandom), pick(), pick(), 1'b0);
    // kill mid-divide, then the unit must still work
    @(negedge clk);
    drv(1'b1, 3'd4, 32'h12345678, 32'h00000123);
    @(posedge clk);
    #1 drv(1'b0, 3'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ctl(1'b1, 1'b0);
    @(posedge clk);
    #1 ctl(1'b0, 1'b0);
    @(negedge clk);
    chk("kill idle", {b1.req_ready, b1.resp_valid, b1.busy, b4.req_ready, b4.resp_valid, b4.busy}, 6'b100100);
    quiet("kill no valid");
    op(3'd5, 32'd9, 32'd3, 1'b0);
    // accept coinciding with kill is dropped
    @(negedge clk);
    drv(1'b1, 3'd5, 32'd9, 32'd3);
    ctl(1'b1, 1'b0);
    @(posedge clk);
    #1 begin drv(1'b0, 3'd0, 32'h0, 32'h0); ctl(1'b0, 1'b0); end
    @(negedge clk);
    chk("kill accept busy", {b1.busy, b4.busy}, 2'b00);
    quiet("kill accept no valid");
    // kill beats resp_ready in DONE
    @(negedge clk);
    drv(1'b1, 3'd5, 32'd7, 32'd0);
    @(posedge clk);
    #1 drv(1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("special valid", {b1.resp_valid, b4.resp_valid}, 2'b11);
    ctl(1'b1, 1'b1);
    @(posedge clk);
    #1 ctl(1'b0, 1'b0);
    @(negedge clk);
    chk("kill done", {b1.req_ready, b1.resp_valid, b1.busy, b4.req_ready, b4.resp_valid, b4.busy}, 6'b100100);
    // reset mid-multiply
    @(negedge clk);
    drv(1'b1, 3'd0, 32'h00012345, 32'h00000777);
    @(posedge clk);
    #1 drv(1'b0, 3'd0, 32'h0, 32'h0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst flags", {b1.req_ready, b1.resp_valid, b1.busy, b4.req_ready, b4.resp_valid, b4.busy}, 6'b100100);
    chk("mid rst result", {b1.resp_result, b4.resp_result}, 64'h0);
    rst = 1'b0;
    quiet("rst no valid");
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
